// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FP multiplier byte-port sequencer.
package fpmul_pkg;

  localparam int DW_DEF = 8;
  localparam int WW_DEF = 32;

  localparam int          STAT_TO_BIT = 7;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  // Core exception flag positions, {NV,DZ,OF,UF,NX}
  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_SEND   = 3'd5
  } state_t;

  // Status byte: timeout in the MSB, core flags in the low five bits.
  function automatic logic [7:0] mk_status(input logic [4:0] flags, input logic timed_out);
    logic [7:0] s;
    s = 8'h00;
    s[FLG_NX]      = flags[FLG_NX];
    s[FLG_UF]      = flags[FLG_UF];
    s[FLG_OF]      = flags[FLG_OF];
    s[FLG_DZ]      = flags[FLG_DZ];
    s[FLG_NV]      = flags[FLG_NV];
    s[STAT_TO_BIT] = timed_out;
    return s;
  endfunction

endpackage

// File: rtl/fpmul_byte_ser.sv
// Multi-byte output serializer, LSB byte first, with valid/ready hold.
module fpmul_byte_ser #(
  parameter int DW = 8,
  parameter int NB = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [NB*DW-1:0] load_data,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last_acc
);

  localparam logic [2:0] LAST = 3'(NB - 1);

  logic [NB*DW-1:0] sh;
  logic [2:0]       idx;
  logic             vld;
  logic             acc;

  assign acc       = vld & out_ready;
  assign last_acc  = acc && (idx == LAST);
  assign out_data  = sh[DW-1:0];
  assign out_valid = vld;

  // Shift register advances one byte per accepted transfer; clr discards the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      idx <= 3'd0;
      vld <= 1'b0;
    end else if (clr) begin
      sh  <= '0;
      idx <= 3'd0;
      vld <= 1'b0;
    end else if (load) begin
      sh  <= load_data;
      idx <= 3'd0;
      vld <= 1'b1;
    end else if (acc) begin
      if (idx == LAST) begin
        vld <= 1'b0;
        idx <= 3'd0;
      end else begin
        sh  <= {{DW{1'b0}}, sh[NB*DW-1:DW]};
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/fpmul_seq_ctrl.sv
// Sequencer between the byte port and the FP multiplier core.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for first byte of A
// LOAD_A   | collecting bytes 1..3 of A
// LOAD_B   | collecting bytes 0..3 of B
// ISSUE    | one-cycle mul_start, timeout counter cleared
// WAIT     | waiting for mul_done or timeout expiry
// SEND     | streaming 4 result bytes then status
module fpmul_seq_ctrl
  import fpmul_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int WW      = WW_DEF,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          soft_clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WW-1:0] mul_a,
  output logic [WW-1:0] mul_b,
  output logic          mul_start,
  input  logic          mul_done,
  input  logic [WW-1:0] mul_result,
  input  logic [4:0]    mul_flags,
  output logic          busy
);

  localparam int NB = WW / DW;
  localparam logic [2:0] LAST_B = 3'(NB - 1);
  // Expiry fires when the counter steps onto TIMEOUT-1, so SEND starts TIMEOUT cycles after ISSUE.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

  state_t state, state_nxt;

  logic [2:0]            byte_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  st_in_rdy;
  logic                  in_acc;
  logic                  expire;
  logic                  ser_load;
  logic                  ser_last;
  logic [(NB+1)*DW-1:0]  ser_data;

  // soft_clr blocks a same-cycle byte; reset keeps every output low while asserted.
  assign in_ready = st_in_rdy & ~soft_clr & wb_rst_ni;
  assign in_acc   = in_valid & in_ready;
  assign expire   = (state == ST_WAIT) && (to_cnt == TO_LAST);
  assign ser_load = (state == ST_WAIT) && (mul_done || expire) && !soft_clr;
  // Done wins over a same-cycle expiry.
  assign ser_data = mul_done ? {mk_status(mul_flags, 1'b0), mul_result}
                             : {mk_status(5'd0, 1'b1), FP_QNAN};

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; soft_clr overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_acc) state_nxt = ST_LOAD_A;
      ST_LOAD_A: if (in_acc && byte_cnt == LAST_B) state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (in_acc && byte_cnt == LAST_B) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT:   if (mul_done || expire) state_nxt = ST_SEND;
      ST_SEND:   if (ser_last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (soft_clr) state_nxt = ST_IDLE;
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    st_in_rdy = 1'b0;
    mul_start = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE:   begin st_in_rdy = 1'b1; busy = 1'b0; end
      ST_LOAD_A: st_in_rdy = 1'b1;
      ST_LOAD_B: st_in_rdy = 1'b1;
      ST_ISSUE:  mul_start = 1'b1;
      default:   ;
    endcase
  end

  // Operand byte fill, LSB first; the byte counter wraps at each phase change.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mul_a    <= '0;
      mul_b    <= '0;
      byte_cnt <= 3'd0;
    end else if (soft_clr) begin
      byte_cnt <= 3'd0;
    end else if (in_acc) begin
      if (state == ST_LOAD_B) mul_b[byte_cnt*DW +: DW] <= in_data;
      else                    mul_a[byte_cnt*DW +: DW] <= in_data;
      byte_cnt <= (byte_cnt == LAST_B) ? 3'd0 : byte_cnt + 3'd1;
    end
  end

  // Watchdog counter: cleared in ISSUE, counts every WAIT cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                          to_cnt <= '0;
    else if (soft_clr || state == ST_ISSUE)  to_cnt <= '0;
    else if (state == ST_WAIT)               to_cnt <= to_cnt + 1'b1;
  end

  fpmul_byte_ser #(
    .DW (DW),
    .NB (NB + 1)
  ) u_ser (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .clr       (soft_clr),
    .load      (ser_load),
    .load_data (ser_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last_acc  (ser_last)
  );

endmodule
